// File: rtl/line_buffer_feeder_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution front end: pixel width, the feeder
// FSM state encoding and helpers for sizing band/row/column indices.
// No ports (package).
// ----------------------------------------------------------------------------
package conv_pkg;

   localparam int PIX_W = 8;

   typedef enum logic [2:0] {
      ST_FILL  = 3'd0,
      ST_PRIME = 3'd1,
      ST_SLIDE = 3'd2,
      ST_LOAD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Number of vertical band positions a FILTER_SIZE-row window takes
   // while sliding down an IMAGE_HEIGHT-row frame.
   function automatic int num_bands(input int image_height, input int filter_size);
      return image_height - filter_size + 1;
   endfunction

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_buffer_feeder_row_bank.sv
// ----------------------------------------------------------------------------
// row_bank
// FILTER_SIZE x IMAGE_WIDTH pixel register array.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (clears storage)
//   wr_en         write wr_data to (wr_row, wr_col)
//   wr_row/wr_col write address
//   wr_data       pixel to write
//   shift_up      move every row up by one; the bottom row keeps its value
//   rows_out      flat band, row i column c at [(i*IMAGE_WIDTH+c)*PIX_W +: PIX_W]
// ----------------------------------------------------------------------------
module row_bank
   import conv_pkg::*;
#(
   parameter int IMAGE_WIDTH = 9,
   parameter int FILTER_SIZE = 3,
   parameter int ROW_W       = idx_w(FILTER_SIZE),
   parameter int COL_W       = idx_w(IMAGE_WIDTH)
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     wr_en,
   input  logic [ROW_W-1:0]                         wr_row,
   input  logic [COL_W-1:0]                         wr_col,
   input  logic [PIX_W-1:0]                         wr_data,
   input  logic                                     shift_up,
   output logic [FILTER_SIZE*IMAGE_WIDTH*PIX_W-1:0] rows_out
);

   localparam int ROW_BITS = IMAGE_WIDTH * PIX_W;
   localparam int BUS_W    = FILTER_SIZE * ROW_BITS;

   logic [BUS_W-1:0] store_q;
   logic [BUS_W-1:0] store_d;

   always_comb begin
      store_d = store_q;
      if (shift_up) begin
         for (int i = 0; i < FILTER_SIZE - 1; i++) begin
            store_d[i*ROW_BITS +: ROW_BITS] = store_q[(i+1)*ROW_BITS +: ROW_BITS];
         end
      end else if (wr_en) begin
         store_d[(int'(wr_row) * IMAGE_WIDTH + int'(wr_col)) * PIX_W +: PIX_W] = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         store_q <= '0;
      end else begin
         store_q <= store_d;
      end
   end

   assign rows_out = store_q;

endmodule

// File: rtl/line_buffer_feeder.sv
// ----------------------------------------------------------------------------
// line_buffer_feeder
// Collects a raster pixel stream into a band of FILTER_SIZE rows, hands the
// band to the window shifter (prime pulse, then column advance enable) and
// slides the band down one image row each time the shifter finishes.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   pix_in          pixel data, accepted when pix_valid && pix_ready
//   pix_valid       producer has a pixel
//   pix_ready       registered; high while filling/loading rows
//   row_buffer_out  band storage, row 0 = oldest row
//   shift_en        one-cycle prime pulse to the shifter
//   shift_buffer    shifter may advance (masked in the new_buffer cycle)
//   new_buffer      shifter finished the current band
//   band_idx        index of the band being presented
//   frame_done      one-cycle pulse after the last band
// ----------------------------------------------------------------------------
module line_buffer_feeder
   import conv_pkg::*;
#(
   parameter int IMAGE_WIDTH  = 9,
   parameter int IMAGE_HEIGHT = 9,
   parameter int FILTER_SIZE  = 3
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [PIX_W-1:0]                         pix_in,
   input  logic                                     pix_valid,
   output logic                                     pix_ready,
   output logic [FILTER_SIZE*IMAGE_WIDTH*PIX_W-1:0] row_buffer_out,
   output logic                                     shift_en,
   output logic                                     shift_buffer,
   input  logic                                     new_buffer,
   output logic [$clog2(IMAGE_HEIGHT)-1:0]          band_idx,
   output logic                                     frame_done
);

   localparam int N_BANDS = num_bands(IMAGE_HEIGHT, FILTER_SIZE);
   localparam int ROW_W   = idx_w(FILTER_SIZE);
   localparam int COL_W   = idx_w(IMAGE_WIDTH);
   localparam int BAND_W  = $clog2(IMAGE_HEIGHT);

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FILTER_SIZE - 1);
   localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(N_BANDS - 1);

   state_t            state_q, state_d;
   logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
   logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
   logic [BAND_W-1:0] band_cnt_q, band_cnt_d;
   logic              pix_ready_q, pix_ready_d;
   logic              shift_en_q, shift_en_d;
   logic              frame_done_q, frame_done_d;

   logic              accept;
   logic              wr_en;
   logic [ROW_W-1:0]  wr_row;
   logic              shift_up;

   assign accept = pix_valid && pix_ready_q;

   always_comb begin
      state_d    = state_q;
      col_cnt_d  = col_cnt_q;
      row_cnt_d  = row_cnt_q;
      band_cnt_d = band_cnt_q;
      wr_en      = 1'b0;
      wr_row     = row_cnt_q;
      shift_up   = 1'b0;

      unique case (state_q)
         ST_FILL: begin
            if (accept) begin
               wr_en = 1'b1;
               if (col_cnt_q == COL_LAST) begin
                  col_cnt_d = '0;
                  if (row_cnt_q == ROW_LAST) begin
                     row_cnt_d = '0;
                     state_d   = ST_PRIME;
                  end else begin
                     row_cnt_d = row_cnt_q + 1'b1;
                  end
               end else begin
                  col_cnt_d = col_cnt_q + 1'b1;
               end
            end
         end

         ST_PRIME: begin
            state_d = ST_SLIDE;
         end

         ST_SLIDE: begin
            if (new_buffer) begin
               if (band_cnt_q < BAND_LAST) begin
                  shift_up   = 1'b1;
                  band_cnt_d = band_cnt_q + 1'b1;
                  state_d    = ST_LOAD;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_LOAD: begin
            // Only the bottom row is refilled; the upper rows came from the slide.
            wr_row = ROW_LAST;
            if (accept) begin
               wr_en = 1'b1;
               if (col_cnt_q == COL_LAST) begin
                  col_cnt_d = '0;
                  state_d   = ST_PRIME;
               end else begin
                  col_cnt_d = col_cnt_q + 1'b1;
               end
            end
         end

         ST_DONE: begin
            col_cnt_d  = '0;
            row_cnt_d  = '0;
            band_cnt_d = '0;
            state_d    = ST_FILL;
         end

         default: begin
            state_d = ST_FILL;
         end
      endcase

      // Registered outputs are decoded from the next state so they line up
      // with the cycle the FSM actually spends in that state.
      pix_ready_d  = (state_d == ST_FILL) || (state_d == ST_LOAD);
      shift_en_d   = (state_d == ST_PRIME);
      frame_done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_FILL;
         col_cnt_q    <= '0;
         row_cnt_q    <= '0;
         band_cnt_q   <= '0;
         pix_ready_q  <= 1'b0;
         shift_en_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_cnt_q    <= col_cnt_d;
         row_cnt_q    <= row_cnt_d;
         band_cnt_q   <= band_cnt_d;
         pix_ready_q  <= pix_ready_d;
         shift_en_q   <= shift_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   row_bank #(
      .IMAGE_WIDTH (IMAGE_WIDTH),
      .FILTER_SIZE (FILTER_SIZE),
      .ROW_W       (ROW_W),
      .COL_W       (COL_W)
   ) u_row_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_row   (wr_row),
      .wr_col   (col_cnt_q),
      .wr_data  (pix_in),
      .shift_up (shift_up),
      .rows_out (row_buffer_out)
   );

   assign pix_ready  = pix_ready_q;
   assign shift_en   = shift_en_q;
   // Combinational mask: the shifter must not advance in the cycle it
   // reports completion, otherwise it would step into the next band early.
   assign shift_buffer = (state_q == ST_SLIDE) && !new_buffer;
   assign band_idx   = band_cnt_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buffer_feeder.sv
module tb_line_buffer_feeder;

   localparam int W         = 9;
   localparam int H         = 9;
   localparam int F         = 3;
   localparam int NB        = H - F + 1;
   localparam int NPIX      = W * H;
   localparam int BUS_W     = F * W * 8;
   localparam int SLIDE_LEN = 7;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       pix_in = 8'd0;
   logic             pix_valid = 1'b0;
   logic             new_buffer = 1'b0;
   logic             pix_ready;
   logic [BUS_W-1:0] row_buffer_out;
   logic             shift_en;
   logic             shift_buffer;
   logic [3:0]       band_idx;
   logic             frame_done;

   line_buffer_feeder #(
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .FILTER_SIZE  (F)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pix_in         (pix_in),
      .pix_valid      (pix_valid),
      .pix_ready      (pix_ready),
      .row_buffer_out (row_buffer_out),
      .shift_en       (shift_en),
      .shift_buffer   (shift_buffer),
      .new_buffer     (new_buffer),
      .band_idx       (band_idx),
      .frame_done     (frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // producer / shifter stand-in
   int prod_idx  = 0;
   int prod_end  = 0;
   int kind      = 0;
   int slide_cnt = 0;
   bit toggle    = 1'b0;
   bit phase     = 1'b0;
   bit stray     = 1'b0;

   // behavioural model of the feeder's observable schedule
   bit m_fresh = 1'b1;
   bit m_prime = 1'b0;
   bit m_slide = 1'b0;
   bit m_done  = 1'b0;
   int m_need  = 0;
   int m_band  = 0;
   int se_cnt  = 0;
   int fd_cnt  = 0;

   function automatic logic [7:0] pix_val(input int k, input int idx);
      if (k == 0) return 8'(idx);
      return 8'((idx * 7 + 3) & 255);
   endfunction

   // band b consists of image rows b .. b+F-1
   function automatic logic [BUS_W-1:0] band_bus(input int k, input int b);
      logic [BUS_W-1:0] v;
      v = '0;
      for (int r = 0; r < F; r++)
         for (int c = 0; c < W; c++)
            v[(r*W+c)*8 +: 8] = pix_val(k, (b + r) * W + c);
      return v;
   endfunction

   function automatic logic [7:0] rb(input int r, input int c);
      return row_buffer_out[(r*W+c)*8 +: 8];
   endfunction

   task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_cycle();
      bit exp_ready;
      if (!rst) begin
         chk("rst_ready", pix_ready, 0);
         chk("rst_shift_en", shift_en, 0);
         chk("rst_shift_buffer", shift_buffer, 0);
         chk("rst_band_idx", band_idx, 0);
         chk("rst_frame_done", frame_done, 0);
         chk("rst_rows", row_buffer_out, 0);
         m_fresh = 1'b1; m_prime = 1'b0; m_slide = 1'b0; m_done = 1'b0;
         m_need = 0; m_band = 0;
         return;
      end
      exp_ready = !m_fresh && (m_need > 0);
      chk("m_pix_ready", pix_ready, exp_ready);
      chk("m_shift_en", shift_en, m_prime);
      chk("m_shift_buffer", shift_buffer, m_slide && !new_buffer);
      chk("m_frame_done", frame_done, m_done);
      chk("m_band_idx", band_idx, m_band);
      if (m_prime || m_slide) chk("m_band_rows", row_buffer_out, band_bus(kind, m_band));
      if (shift_en) se_cnt++;
      if (frame_done) fd_cnt++;
      if (m_fresh) begin
         m_fresh = 1'b0; m_need = F * W; m_band = 0;
      end else if (m_need > 0) begin
         if (pix_valid) begin
            m_need--;
            if (m_need == 0) m_prime = 1'b1;
         end
      end else if (m_prime) begin
         m_prime = 1'b0; m_slide = 1'b1;
      end else if (m_slide) begin
         if (new_buffer) begin
            m_slide = 1'b0;
            if (m_band < NB - 1) begin
               m_band++; m_need = W;
            end else begin
               m_done = 1'b1;
            end
         end
      end else if (m_done) begin
         m_done = 1'b0; m_band = 0; m_need = F * W;
      end
   endtask

   // One clock: model check at the negedge, then drive inputs 1 after posedge.
   task automatic step();
      bit acc, sb, nb;
      @(negedge clk);
      model_cycle();
      acc = pix_valid && pix_ready;
      sb  = shift_buffer;
      @(posedge clk);
      #1;
      if (acc) prod_idx++;
      nb = 1'b0;
      if (sb) begin
         slide_cnt++;
         if (slide_cnt == SLIDE_LEN) begin
            nb = 1'b1; slide_cnt = 0;
         end
      end
      if (stray) begin
         nb = 1'b1; stray = 1'b0;
      end
      new_buffer = nb;
      phase      = ~phase;
      pix_valid  = (prod_idx < prod_end) && (!toggle || phase);
      pix_in     = pix_val(kind, prod_idx % NPIX);
   endtask

   function automatic bit cond(input int which);
      case (which)
         0: return shift_en;
         1: return new_buffer;
         2: return frame_done;
         3: return band_idx == 4'd1;
         default: return prod_idx == 31;
      endcase
   endfunction

   task automatic wait_for(input int which, input string name, input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         step();
         hit = cond(which);
      end
      if (!hit) begin
         n_cmp++; n_fail++;
         $display("FAIL %s: event not seen within %0d cycles", name, budget);
      end
   endtask

   task automatic run_frame(input int k, input bit tog, input string name);
      int se0, fd0;
      kind = k; toggle = tog; prod_idx = 0; prod_end = NPIX;
      se0 = se_cnt; fd0 = fd_cnt;
      wait_for(2, name, 1500);
      chk({name, "_r0c0"}, rb(0, 0), pix_val(k, 54));
      chk({name, "_r1c0"}, rb(1, 0), pix_val(k, 63));
      chk({name, "_r2c8"}, rb(2, 8), pix_val(k, 80));
      step();
      chk({name, "_prime_cnt"}, se_cnt - se0, NB);
      chk({name, "_done_cnt"}, fd_cnt - fd0, 1);
      chk({name, "_accepts"}, prod_idx, NPIX);
      chk({name, "_fd_low"}, frame_done, 0);
      chk({name, "_band0"}, band_idx, 0);
      chk({name, "_ready"}, pix_ready, 1);
      toggle = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (3) step();
      chk("reset_ready", pix_ready, 0);
      chk("reset_rows", row_buffer_out, 0);
      chk("reset_band", band_idx, 0);
      chk("reset_shift_en", shift_en, 0);
      chk("reset_frame_done", frame_done, 0);
      rst = 1'b1;
      step();
      chk("ready_after_release", pix_ready, 1);

      // first band fill, prime, slide, second band
      kind = 0; prod_idx = 0; prod_end = NPIX;
      wait_for(0, "prime1", 200);
      chk("fill_accepts", prod_idx, 27);
      chk("fill_ready_low", pix_ready, 0);
      chk("prime1_sb", shift_buffer, 0);
      chk("fill_r0c0", rb(0, 0), 8'd0);
      chk("fill_r1c0", rb(1, 0), 8'd9);
      chk("fill_r2c8", rb(2, 8), 8'd26);
      step();
      chk("slide_se_low", shift_en, 0);
      chk("slide_sb_high", shift_buffer, 1);
      wait_for(1, "nb1", 50);
      #1;
      chk("nb_masks_sb", shift_buffer, 0);
      step();
      chk("band1_r0c0", rb(0, 0), 8'd9);
      chk("band1_r1c8", rb(1, 8), 8'd26);
      chk("band1_idx", band_idx, 4'd1);
      chk("band1_ready", pix_ready, 1);
      wait_for(0, "prime2", 100);
      chk("band1_r2c0", rb(2, 0), 8'd27);
      chk("band1_r2c8", rb(2, 8), 8'd35);
      chk("band1_accepts", prod_idx, 36);
      wait_for(2, "done1", 1500);
      chk("frame1_r0c0", rb(0, 0), 8'd54);
      chk("frame1_r1c0", rb(1, 0), 8'd63);
      chk("frame1_r2c8", rb(2, 8), 8'd80);
      step();
      chk("frame1_primes", se_cnt, 7);
      chk("frame1_dones", fd_cnt, 1);
      chk("frame1_band0", band_idx, 0);
      chk("frame1_ready", pix_ready, 1);

      // gappy producer
      run_frame(0, 1'b1, "toggle");

      // different pixel values, stray new_buffer pulses while filling/loading
      kind = 1; prod_idx = 0; prod_end = NPIX;
      repeat (3) step();
      stray = 1'b1;
      wait_for(3, "stray_band1", 300);
      stray = 1'b1;
      wait_for(2, "stray_done", 1500);
      chk("stray_r0c0", rb(0, 0), pix_val(1, 54));
      chk("stray_r2c8", rb(2, 8), pix_val(1, 80));
      step();
      chk("stray_accepts", prod_idx, NPIX);

      // reset while loading band 1 at column 4
      kind = 0; prod_idx = 0; prod_end = NPIX;
      wait_for(4, "mid_load", 300);
      rst = 1'b0;
      #1;
      chk("midrst_ready", pix_ready, 0);
      chk("midrst_rows", row_buffer_out, 0);
      chk("midrst_band", band_idx, 0);
      chk("midrst_se", shift_en, 0);
      chk("midrst_sb", shift_buffer, 0);
      chk("midrst_fd", frame_done, 0);
      prod_idx = 0; prod_end = 0; slide_cnt = 0;
      repeat (2) step();
      rst = 1'b1;
      step();
      run_frame(0, 1'b0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/line_buffer_feeder.md
Name: line_buffer_feeder

Overview:
- Upstream stage of the window shifter. Accepts a raster-order 8-bit pixel stream and assembles a band of FILTER_SIZE image rows.
- Presents the band as a packed row buffer and sequences the shifter with shift_en and shift_buffer. On each new_buffer it slides the band down one image row.
- Emits frame_done after the last band of the frame, i.e. band N-1 where N = IMAGE_HEIGHT-FILTER_SIZE+1.

Parameters:
- IMAGE_WIDTH, 9, pixels per row.
- IMAGE_HEIGHT, 9, rows per frame.
- FILTER_SIZE, 3, rows held per band. Must satisfy 2 <= FILTER_SIZE <= IMAGE_HEIGHT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- pix_in  in  8  pixel data.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  block accepts a pixel this cycle.
- row_buffer_out  out  FILTER_SIZE*IMAGE_WIDTH*8  band; row i, column c at bits [(i*IMAGE_WIDTH+c)*8 +: 8]; row 0 is the topmost (oldest) row.
- shift_en  out  1  one-cycle prime pulse to the shifter.
- shift_buffer  out  1  shifter may advance its column.
- new_buffer  in  1  shifter finished the current band (registered one-cycle pulse).
- band_idx  out  $clog2(IMAGE_HEIGHT)  index of the band currently presented, 0..N-1.
- frame_done  out  1  one-cycle pulse at the end of the frame.

Behaviour:
- Reset: state=FILL, all counters 0, row storage all zero. pix_ready=0, shift_en=0, shift_buffer=0, band_idx=0, frame_done=0. Reset is honoured in any state; an in-progress frame is abandoned.
- Handshake: a pixel is accepted when pix_valid && pix_ready. pix_ready is registered and high only in FILL and LOAD; pix_ready=1 the first cycle after reset release. Pixels arriving while pix_ready=0 are neither consumed nor lost, since the producer must hold them.
- Counters: col_cnt (0..IMAGE_WIDTH-1), row_cnt (0..FILTER_SIZE-1), band_cnt (0..N-1).
- FILL: accepted pixel written to row[row_cnt][col_cnt]; col_cnt wraps at IMAGE_WIDTH-1 and increments row_cnt. Accepting pixel (FILTER_SIZE-1, IMAGE_WIDTH-1) -> PRIME, pix_ready drops the next cycle.
- PRIME (1 cycle): shift_en=1 (registered), shift_buffer=0 -> SLIDE.
- SLIDE: shift_buffer = (state==SLIDE) && !new_buffer. This is combinational gating so the shifter never sees shift_buffer high in the new_buffer cycle.
- On new_buffer in SLIDE, if band_cnt < N-1:
  - rows shift up in the same edge (row[i] <= row[i+1] for i < FILTER_SIZE-1; row[FILTER_SIZE-1] unchanged until overwritten);
  - band_cnt++ -> LOAD.
- On new_buffer in SLIDE, if band_cnt == N-1 -> DONE.
- LOAD: accepted pixel written to row[FILTER_SIZE-1][col_cnt]. Accepting column IMAGE_WIDTH-1 -> PRIME.
- DONE (1 cycle): frame_done=1; counters and band_idx cleared; row storage retained -> FILL.
- band_idx = band_cnt, registered, updated on the same edge as band_cnt.
- new_buffer outside SLIDE is ignored.
- shift_en and shift_buffer are never high in the same cycle.
- row_buffer_out is driven directly from storage with no added latency. It changes only on pixel-accept edges and on the slide edge.
- Frame rate bound: per band, IMAGE_WIDTH load cycles + 1 PRIME cycle + the shifter's slide cycles. No overlap of loading and sliding.

Decomposition:
- Shared package (conv_pkg):
  - PIX_W=8;
  - state encoding FILL/PRIME/SLIDE/LOAD/DONE;
  - function computing N from IMAGE_HEIGHT and FILTER_SIZE.
- One natural sub-module, row_bank: FILTER_SIZE×IMAGE_WIDTH register array with row-addressed pixel write, whole-array shift-up, and flat packed read port. The FSM and counters stay in line_buffer_feeder.

Test Plan:
- Reset, then stream pixels 0..26 with pix_valid=1 held:
  - 27 accepts, then pix_ready=0;
  - row_buffer_out rows = {0..8}, {9..17}, {18..26};
  - shift_en high exactly one cycle with shift_buffer=0;
  - shift_buffer=1 from the following cycle.
- Continue from the previous case; pulse new_buffer after 7 SLIDE cycles:
  - shift_buffer=0 in the new_buffer cycle;
  - next cycle rows 0/1 = {9..17}, {18..26}; band_idx=1; pix_ready=1.
  - Stream 27..35: row 2 = {27..35}, then one shift_en pulse.
- Full 9x9 frame (pixel value = r*9+c) against a behavioural shifter model:
  - exactly 7 shift_en pulses and 7 bands;
  - final band rows {54..62}, {63..71}, {72..80};
  - frame_done single pulse after the 7th new_buffer;
  - band_idx=0 and pix_ready=1 afterwards.
- pix_valid toggled every other cycle over a full frame: band contents identical to the previous case; no dropped or duplicated pixels.
- pix_valid held high during PRIME and SLIDE: zero accepts; stray new_buffer pulses in FILL and LOAD cause no state change.
- rst asserted mid-LOAD (col_cnt=4): all outputs zero immediately; after release a fresh frame of 81 pixels reproduces the full-frame results.
